// File: rtl/poly_mod_add_pipe_pkg.sv
// Shared constants and types for the poly unit's modular add/diff datapaths (q = 3329).
package poly_mod_add_pipe_pkg;

    localparam int WIDTH = 12;
    localparam int Q     = 3329;
    localparam int Q2    = 2 * Q;
    localparam int NCOEF = 256;
    localparam int CNT_W = 8;

    typedef logic [WIDTH-1:0] coef_t;
    typedef logic [WIDTH:0]   sum_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam sum_t Q_SUM    = sum_t'(Q);
    localparam sum_t Q2_SUM   = sum_t'(Q2);
    localparam cnt_t LAST_IDX = cnt_t'(NCOEF - 1);

endpackage

// File: rtl/poly_mod_add_pipe_if.sv
// Coefficient stream bundle: operand pair in, reduced sum with index/last tag out.
interface poly_mod_add_pipe_if;

    logic                         in_valid;
    logic                         in_ready;
    poly_mod_add_pipe_pkg::coef_t a;
    poly_mod_add_pipe_pkg::coef_t b;
    logic                         out_valid;
    logic                         out_ready;
    poly_mod_add_pipe_pkg::coef_t o;
    poly_mod_add_pipe_pkg::cnt_t  out_idx;
    logic                         out_last;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, o, out_idx, out_last
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, o, out_idx, out_last
    );

endinterface

// File: rtl/poly_mod_add_pipe_red2.sv
// Full reduction of a value below 3q into 0..q-1 using two conditional subtracts.
module poly_mod_red2
    import poly_mod_add_pipe_pkg::*;
(
    input  sum_t  sum,
    output coef_t o
);

    sum_t r1;

    // Largest input is 2*4095 = 8190, and 8190 - 2q = 1532 < q, so two steps are enough.
    always_comb begin
        r1 = (sum >= Q_SUM) ? sum - Q_SUM : sum;
        o  = coef_t'((r1 >= Q_SUM) ? r1 - Q_SUM : r1);
    end

endmodule

// File: rtl/poly_mod_add_pipe.sv
// Two-stage elastic pipeline computing (a+b) mod q per beat, tagging each coefficient's index.
module poly_mod_add_pipe
    import poly_mod_add_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    poly_mod_add_pipe_if.slave   bus
);

    logic  s1_v_q,   s1_v_d;
    sum_t  sum_q,    sum_d;
    cnt_t  s1_idx_q, s1_idx_d;
    logic  s2_v_q,   s2_v_d;
    coef_t o_q,      o_d;
    cnt_t  s2_idx_q, s2_idx_d;
    logic  last_q,   last_d;
    cnt_t  cnt_q,    cnt_d;

    logic  s2_load;
    logic  s1_load;
    logic  in_ready;
    logic  accept;
    coef_t red_o;

    poly_mod_red2 u_red (
        .sum (sum_q),
        .o   (red_o)
    );

    always_comb begin
        s2_load  = !s2_v_q || bus.out_ready;
        s1_load  = !s1_v_q || s2_load;
        in_ready = !rst && s1_load;
        accept   = bus.in_valid && in_ready;

        s1_v_d   = s1_v_q;
        sum_d    = sum_q;
        s1_idx_d = s1_idx_q;
        s2_v_d   = s2_v_q;
        o_d      = o_q;
        s2_idx_d = s2_idx_q;
        last_d   = last_q;
        cnt_d    = cnt_q;

        // Output registers only change on a load carrying real data, so a stalled beat holds.
        if (s2_load) begin
            s2_v_d = s1_v_q;
            last_d = s1_v_q && (s1_idx_q == LAST_IDX);
            if (s1_v_q) begin
                o_d      = red_o;
                s2_idx_d = s1_idx_q;
            end
        end

        if (s1_load) begin
            s1_v_d = accept;
            if (accept) begin
                sum_d    = {1'b0, bus.a} + {1'b0, bus.b};
                s1_idx_d = cnt_q;
            end
        end

        if (accept) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            sum_q    <= '0;
            s1_idx_q <= '0;
            s2_v_q   <= 1'b0;
            o_q      <= '0;
            s2_idx_q <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            sum_q    <= sum_d;
            s1_idx_q <= s1_idx_d;
            s2_v_q   <= s2_v_d;
            o_q      <= o_d;
            s2_idx_q <= s2_idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_v_q;
    assign bus.o         = o_q;
    assign bus.out_idx   = s2_idx_q;
    assign bus.out_last  = last_q;

endmodule

// File: tb/tb_poly_mod_add_pipe.sv
// Self-checking bench: directed vectors plus randomized streams against a queue-based model.
module tb_poly_mod_add_pipe;

    localparam int TQ     = 3329;
    localparam int TNCOEF = 256;

    typedef struct packed {
        logic [11:0] o;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;

    poly_mod_add_pipe_if bif ();

    poly_mod_add_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int   checks;
    int   errors;
    exp_t sb[$];
    int   modelIdx;
    int   accCount;
    int   emitCount;
    int   lastCount;
    int   lastO;
    int   lastIdx;
    logic stallPrev;
    exp_t prevOut;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Pops the model's oldest expected beat and compares it with what the DUT emits now.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checkVal("unexpected_output", 32'(bif.out_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            checkVal("out_o", 32'(bif.o), 32'(e.o));
            checkVal("out_idx", 32'(bif.out_idx), 32'(e.idx));
            checkVal("out_last", 32'(bif.out_last), 32'(e.last));
            if (e.last) lastCount++;
        end
        emitCount++;
        lastO   = int'(bif.o);
        lastIdx = int'(bif.out_idx);
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] av, input logic [11:0] bv,
                                 input logic r);
        exp_t e;
        int   s;
        @(negedge clk);
        bif.in_valid  = v;
        bif.a         = av;
        bif.b         = bv;
        bif.out_ready = r;
        #1;
        if (stallPrev) begin
            checkVal("hold_valid", 32'(bif.out_valid), 32'd1);
            checkVal("hold_o", 32'(bif.o), 32'(prevOut.o));
            checkVal("hold_idx", 32'(bif.out_idx), 32'(prevOut.idx));
            checkVal("hold_last", 32'(bif.out_last), 32'(prevOut.last));
        end
        if (bif.out_valid && r) checkOutput();
        if (v && bif.in_ready) begin
            s      = int'(av) + int'(bv);
            e.o    = 12'(s % TQ);
            e.idx  = 8'(modelIdx);
            e.last = (modelIdx == TNCOEF - 1);
            sb.push_back(e);
            modelIdx = (modelIdx + 1) % TNCOEF;
            accCount++;
        end
        stallPrev    = bif.out_valid && !r;
        prevOut.o    = bif.o;
        prevOut.idx  = bif.out_idx;
        prevOut.last = bif.out_last;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst           = 1'b1;
        bif.in_valid  = 1'b1;
        bif.a         = 12'($urandom);
        bif.b         = 12'($urandom);
        bif.out_ready = 1'b1;
        #1;
        checkVal("rst_in_ready", 32'(bif.in_ready), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bif.in_valid = 1'b0;
        #1;
        checkVal("rst_out_valid", 32'(bif.out_valid), 32'd0);
        checkVal("rst_o", 32'(bif.o), 32'd0);
        checkVal("rst_out_idx", 32'(bif.out_idx), 32'd0);
        checkVal("rst_out_last", 32'(bif.out_last), 32'd0);
        checkVal("rst_in_ready_after", 32'(bif.in_ready), 32'd1);
        sb.delete();
        modelIdx  = 0;
        stallPrev = 1'b0;
        accCount  = 0;
        emitCount = 0;
        lastCount = 0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (sb.size() > 0 && g < 20) begin
            applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
            g++;
        end
        checkVal(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int g;
        checks        = 0;
        errors        = 0;
        modelIdx      = 0;
        stallPrev     = 1'b0;
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.a         = '0;
        bif.b         = '0;
        bif.out_ready = 1'b0;

        // Test 1: directed corner vectors and two-cycle latency
        doReset();
        applyStimulus(1'b1, 12'd3328, 12'd3328, 1'b1);
        applyStimulus(1'b1, 12'd4095, 12'd4095, 1'b1);
        checkVal("lat_cycle1_invalid", 32'(bif.out_valid), 32'd0);
        applyStimulus(1'b1, 12'd1, 12'd3328, 1'b1);
        checkVal("lat_cycle2_valid", 32'(bif.out_valid), 32'd1);
        checkVal("vec_3328_3328", 32'(lastO), 32'd3327);
        applyStimulus(1'b1, 12'd0, 12'd0, 1'b1);
        checkVal("vec_4095_4095", 32'(lastO), 32'd1532);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
        checkVal("vec_1_3328", 32'(lastO), 32'd0);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
        checkVal("vec_0_0", 32'(lastO), 32'd0);
        checkVal("vec_0_0_idx", 32'(lastIdx), 32'd3);
        drain("t1_drain");

        // Test 2: one polynomial back-to-back
        doReset();
        for (int i = 0; i < 256; i++)
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b1);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
        checkVal("t2_emitted", 32'(emitCount), 32'd256);
        checkVal("t2_last_count", 32'(lastCount), 32'd1);
        checkVal("t2_idx_final", 32'(lastIdx), 32'd255);

        // Test 3: two polynomials, index wrap with no gap
        doReset();
        for (int i = 0; i < 512; i++)
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b1);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
        applyStimulus(1'b0, 12'd0, 12'd0, 1'b1);
        checkVal("t3_emitted", 32'(emitCount), 32'd512);
        checkVal("t3_last_count", 32'(lastCount), 32'd2);

        // Test 4: downstream stall mid-stream for 5 cycles
        doReset();
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b0);
            if (i >= 2) checkVal("t4_in_ready_stall", 32'(bif.in_ready), 32'd0);
        end
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b1);
        drain("t4_drain");
        checkVal("t4_no_loss", 32'(emitCount), 32'(accCount));

        // Test 5: random valid/ready toggling
        doReset();
        g = 0;
        while (accCount < 1000 && g < 8000) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom),
                          1'($urandom_range(0, 1)));
            g++;
        end
        checkVal("t5_accept_budget", 32'(accCount >= 1000), 32'd1);
        drain("t5_drain");
        checkVal("t5_no_loss", 32'(emitCount), 32'(accCount));

        // Test 6: reset at beat 100 with both stages full
        doReset();
        g = 0;
        while (accCount < 100 && g < 200) begin
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b1);
            g++;
        end
        applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b0);
        checkVal("t6_full_in_ready", 32'(bif.in_ready), 32'd0);
        checkVal("t6_full_out_valid", 32'(bif.out_valid), 32'd1);
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 12'($urandom), 12'($urandom), 1'b1);
        checkVal("t6_first_idx", 32'(emitCount > 0 && lastIdx <= 2), 32'd1);
        drain("t6_drain");
        checkVal("t6_count", 32'(emitCount), 32'd5);
        checkVal("t6_final_idx", 32'(lastIdx), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
